// File: rtl/sprite_pkg.sv
// Shared types for the sprite line renderer: OAM entry layout, pixel constants
// and the renderer FSM state encoding.
package sprite_pkg;

    localparam logic [3:0] TRANSPARENT = 4'h0;
    localparam int unsigned SPRITE_H = 16;
    localparam int unsigned SPRITE_W = 16;

    typedef struct packed {
        logic       enable;
        logic       yflip;
        logic       xflip;
        logic       prio;
        logic [9:0] ypos;
        logic [9:0] xpos;
        logic [7:0] spriteref;
    } oam_entry_t;

    typedef enum logic [2:0] {
        StIdle,
        StWaitReady,
        StOamFetch,
        StOamLatch,
        StSprFetch,
        StDraw,
        StNext,
        StDone
    } render_state_e;

endpackage

// File: rtl/sprite_line_renderer_if.sv
// Evaluator list plus OAM / sprite-memory read bus seen by the line renderer.
// The renderer is the master: it drives both read addresses.
interface sprite_line_renderer_if #(
    parameter int unsigned maxObjectPerLine = 32,
    parameter int unsigned OAM_ADDR_SIZE    = 6,
    parameter int unsigned SPRITE_ADDR_SIZE = 12
);
    logic [maxObjectPerLine*(OAM_ADDR_SIZE+1)-1:0] buffer_array;
    logic                                          line_prepared;
    logic [OAM_ADDR_SIZE-1:0]                      oam_addr;
    logic [31:0]                                   oam_data;
    logic [SPRITE_ADDR_SIZE-1:0]                   spr_addr;
    logic [63:0]                                   spr_data;

    modport master (
        input  buffer_array, line_prepared, oam_data, spr_data,
        output oam_addr, spr_addr
    );

    modport slave (
        output buffer_array, line_prepared, oam_data, spr_data,
        input  oam_addr, spr_addr
    );
endinterface

// File: rtl/line_buffer_dp.sv
// One half of the double-buffered sprite line memory. Colour/priority live in
// an unreset array; occupancy lives in a flop mask so a whole line clears in
// one cycle. Reads are combinational; invalid pixels read back as zero.
module line_buffer_dp #(
    parameter int unsigned LINE_WIDTH = 640
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       wr_en,
    input  logic [9:0] wr_addr,
    input  logic [3:0] wr_color,
    input  logic       wr_prio,
    input  logic [9:0] rd_addr,
    output logic       rd_valid,
    output logic [3:0] rd_color,
    output logic       rd_prio,
    output logic       wr_occupied
);
    logic [LINE_WIDTH-1:0] mask_q;
    logic [4:0]            mem_q [LINE_WIDTH];

    // Occupancy mask; a clear wins over a simultaneous write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= '0;
        end else if (clear) begin
            mask_q <= '0;
        end else if (wr_en) begin
            mask_q[wr_addr] <= 1'b1;
        end
    end

    // Pixel storage; only meaningful where the mask bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= {wr_color, wr_prio};
        end
    end

    // Read port and write-side occupancy lookup.
    always_comb begin
        rd_valid    = 1'b0;
        rd_color    = '0;
        rd_prio     = 1'b0;
        wr_occupied = 1'b0;
        if ({1'b0, rd_addr} < 11'(LINE_WIDTH)) begin
            rd_valid = mask_q[rd_addr];
            if (mask_q[rd_addr]) begin
                {rd_color, rd_prio} = mem_q[rd_addr];
            end
        end
        if ({1'b0, wr_addr} < 11'(LINE_WIDTH)) begin
            wr_occupied = mask_q[wr_addr];
        end
    end
endmodule

// File: rtl/sprite_line_renderer.sv
// Per-line sprite renderer: walks the evaluator's packed sprite list, fetches
// each sprite's OAM entry and row, and draws it into the back line buffer while
// the front buffer feeds the pixel output. Buffers swap on every sy change.
// Optional: define SPRITE_COLLISION_EN to build the sticky overlap detector.
module sprite_line_renderer
    import sprite_pkg::*;
#(
    parameter int unsigned maxObjectPerLine = 32,
    parameter int unsigned OAM_ADDR_SIZE    = 6,
    parameter int unsigned LINE_WIDTH       = 640,
    parameter int unsigned SPRITE_ADDR_SIZE = 12
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [9:0]                    sx,
    input  logic [9:0]                    sy,
    sprite_line_renderer_if.master        bus,
    output logic [3:0]                    pixel_color,
    output logic                          pixel_priority,
    output logic                          pixel_valid,
    output logic                          render_done,
    output logic                          sprite_collision
);
    localparam int unsigned EntryW = OAM_ADDR_SIZE + 1;
    localparam int unsigned IdxW   = $clog2(maxObjectPerLine + 1);

    render_state_e     state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [3:0]        pix_i_q, pix_i_d;
    logic [9:0]        sy_q;
    logic              front_sel_q;
    logic [9:0]        xpos_q;
    logic              xflip_q, prio_q;
    logic [63:0]       spr_q;
    logic [3:0]        pixel_color_q;
    logic              pixel_priority_q, pixel_valid_q;

    logic              swap;
    logic [EntryW-1:0] entry;
    logic              list_end;
    oam_entry_t        oam_in;
    logic [9:0]        row_diff;
    logic [3:0]        row;
    logic              row_hit;
    logic [3:0]        src_i;
    logic [3:0]        draw_pix;
    logic [10:0]       draw_x;
    logic              draw_opaque, back_occupied, draw_we;

    logic              valid0, valid1, prio0, prio1, occ0, occ1;
    logic [3:0]        color0, color1;

    assign swap   = (sy != sy_q);
    assign oam_in = oam_entry_t'(bus.oam_data);

    // Current list entry; past the end of the array reads as an invalid entry.
    always_comb begin
        entry    = '0;
        list_end = 1'b1;
        if (idx_q < IdxW'(maxObjectPerLine)) begin
            entry    = bus.buffer_array[int'(idx_q)*EntryW +: EntryW];
            list_end = !entry[0];
        end
    end

    // Sprite row selection from the freshly read OAM word.
    always_comb begin
        row_diff = sy - oam_in.ypos;
        row      = oam_in.yflip ? ~row_diff[3:0] : row_diff[3:0];
        row_hit  = oam_in.enable && (row_diff < 10'(SPRITE_H));
    end

    // Draw datapath: ~i is 15-i for the mirrored source pixel.
    always_comb begin
        src_i         = xflip_q ? ~pix_i_q : pix_i_q;
        draw_pix      = spr_q[{src_i, 2'b00} +: 4];
        draw_x        = {1'b0, xpos_q} + {7'b0, pix_i_q};
        back_occupied = front_sel_q ? occ0 : occ1;
        draw_opaque   = (state_q == StDraw) && (draw_x < 11'(LINE_WIDTH))
                        && (draw_pix != TRANSPARENT);
        // Earlier list entries own a pixel; no writes land on the swap edge.
        draw_we       = draw_opaque && !back_occupied && !swap;
    end

    // FSM next state and read-address outputs.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pix_i_d      = pix_i_q;
        bus.oam_addr = '0;
        bus.spr_addr = '0;
        unique case (state_q)
            StIdle:      state_d = StWaitReady;
            StWaitReady: begin
                idx_d = '0;
                if (bus.line_prepared) state_d = StOamFetch;
            end
            StOamFetch: begin
                bus.oam_addr = entry[EntryW-1:1];
                state_d      = list_end ? StDone : StOamLatch;
            end
            StOamLatch: begin
                if (row_hit) begin
                    bus.spr_addr = SPRITE_ADDR_SIZE'({oam_in.spriteref, row});
                    state_d      = StSprFetch;
                end else begin
                    state_d = StNext;
                end
            end
            StSprFetch: begin
                pix_i_d = '0;
                state_d = StDraw;
            end
            StDraw: begin
                pix_i_d = pix_i_q + 4'd1;
                if (pix_i_q == 4'(SPRITE_W - 1)) state_d = StNext;
            end
            StNext: begin
                idx_d   = idx_q + 1'b1;
                state_d = StOamFetch;
            end
            StDone:  state_d = StDone;
            default: state_d = StIdle;
        endcase
        // A new line aborts whatever is in flight.
        if (swap) begin
            state_d = StWaitReady;
            idx_d   = '0;
        end
    end

    // FSM, line tracking and front/back select.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            pix_i_q     <= '0;
            sy_q        <= '0;
            front_sel_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pix_i_q     <= pix_i_d;
            sy_q        <= sy;
            front_sel_q <= front_sel_q ^ swap;
        end
    end

    // Latched sprite attributes and pixel row.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xpos_q  <= '0;
            xflip_q <= 1'b0;
            prio_q  <= 1'b0;
            spr_q   <= '0;
        end else begin
            if (state_q == StOamLatch) begin
                xpos_q  <= oam_in.xpos;
                xflip_q <= oam_in.xflip;
                prio_q  <= oam_in.prio;
            end
            if (state_q == StSprFetch) begin
                spr_q <= bus.spr_data;
            end
        end
    end

    line_buffer_dp #(.LINE_WIDTH(LINE_WIDTH)) u_buf0 (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (swap && !front_sel_q),
        .wr_en       (draw_we && front_sel_q),
        .wr_addr     (draw_x[9:0]),
        .wr_color    (draw_pix),
        .wr_prio     (prio_q),
        .rd_addr     (sx),
        .rd_valid    (valid0),
        .rd_color    (color0),
        .rd_prio     (prio0),
        .wr_occupied (occ0)
    );

    line_buffer_dp #(.LINE_WIDTH(LINE_WIDTH)) u_buf1 (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (swap && front_sel_q),
        .wr_en       (draw_we && !front_sel_q),
        .wr_addr     (draw_x[9:0]),
        .wr_color    (draw_pix),
        .wr_prio     (prio_q),
        .rd_addr     (sx),
        .rd_valid    (valid1),
        .rd_color    (color1),
        .rd_prio     (prio1),
        .wr_occupied (occ1)
    );

    // Registered pixel output from the front half.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel_color_q    <= '0;
            pixel_priority_q <= 1'b0;
            pixel_valid_q    <= 1'b0;
        end else begin
            pixel_color_q    <= front_sel_q ? color1 : color0;
            pixel_priority_q <= front_sel_q ? prio1 : prio0;
            pixel_valid_q    <= front_sel_q ? valid1 : valid0;
        end
    end

    assign pixel_color    = pixel_color_q;
    assign pixel_priority = pixel_priority_q;
    assign pixel_valid    = pixel_valid_q;
    assign render_done    = (state_q == StDone);

`ifdef SPRITE_COLLISION_EN
    logic collision_q;

    // Sticky overlap flag, cleared by the line swap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            collision_q <= 1'b0;
        end else if (swap) begin
            collision_q <= 1'b0;
        end else if (draw_opaque && back_occupied) begin
            collision_q <= 1'b1;
        end
    end

    assign sprite_collision = collision_q;
`else
    assign sprite_collision = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_line_renderer.sv
// Directed bench for sprite_line_renderer: OAM and sprite memories are modelled
// as 1-cycle synchronous reads; each step renders a line, swaps, and reads back.
`timescale 1ns/1ps
module tb_sprite_line_renderer;
    import sprite_pkg::*;

    localparam int unsigned MaxObj = 32;
    localparam int unsigned OamW   = 6;
    localparam int unsigned LineW  = 640;
    localparam int unsigned SprAw  = 12;
    localparam int unsigned ListW  = MaxObj * (OamW + 1);

`ifdef SPRITE_COLLISION_EN
    localparam logic ExpColl = 1'b1;
`else
    localparam logic ExpColl = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] sx = '0;
    logic [9:0] sy = '0;
    logic [3:0] pixel_color;
    logic       pixel_priority, pixel_valid, render_done, sprite_collision;

    int checks = 0;
    int errors = 0;

    logic [31:0] oam_mem [64];
    logic [63:0] spr_mem [4096];

    sprite_line_renderer_if #(
        .maxObjectPerLine (MaxObj),
        .OAM_ADDR_SIZE    (OamW),
        .SPRITE_ADDR_SIZE (SprAw)
    ) bus ();

    sprite_line_renderer #(
        .maxObjectPerLine (MaxObj),
        .OAM_ADDR_SIZE    (OamW),
        .LINE_WIDTH       (LineW),
        .SPRITE_ADDR_SIZE (SprAw)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .sx               (sx),
        .sy               (sy),
        .bus              (bus),
        .pixel_color      (pixel_color),
        .pixel_priority   (pixel_priority),
        .pixel_valid      (pixel_valid),
        .render_done      (render_done),
        .sprite_collision (sprite_collision)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus.oam_data <= oam_mem[bus.oam_addr];
        bus.spr_data <= spr_mem[bus.spr_addr];
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_oam(input logic en, input logic yf, input logic xf,
                                           input logic pr, input logic [9:0] yp,
                                           input logic [9:0] xp, input logic [7:0] sref);
        return {en, yf, xf, pr, yp, xp, sref};
    endfunction

    function automatic logic [ListW-1:0] mk_list(input int n, input logic [5:0] i0,
                                                 input logic [5:0] i1, input logic [5:0] i2);
        logic [ListW-1:0] l;
        l = '0;
        if (n > 0) l[6:0]   = {i0, 1'b1};
        if (n > 1) l[13:7]  = {i1, 1'b1};
        if (n > 2) l[20:14] = {i2, 1'b1};
        return l;
    endfunction

    // Reads front[x] and checks valid and color (two comparisons).
    task automatic px(input string tag, input logic [9:0] x, input logic ev,
                      input logic [3:0] ec);
        @(negedge clk);
        sx = x;
        @(posedge clk);
        #1;
        check({tag, "_valid"}, 32'(pixel_valid), 32'(ev));
        check({tag, "_color"}, 32'(pixel_color), 32'(ec));
    endtask

    // Changes sy (swap) and waits, bounded, for the new back buffer to finish.
    task automatic render_line(input logic [9:0] line);
        int n;
        @(negedge clk);
        sy = line;
        bus.line_prepared = 1'b1;
        @(negedge clk);
        check("done_clr_on_swap", 32'(render_done), 32'd0);
        n = 0;
        while (render_done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("render_done", 32'(render_done), 32'd1);
    endtask

    task automatic wait_draw(input int entry_idx);
        int n;
        n = 0;
        while (!(dut.state_q == StDraw && int'(dut.idx_q) == entry_idx) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reach_draw", 32'(n < 2000), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) oam_mem[i] = '0;
        for (int i = 0; i < 4096; i++) spr_mem[i] = '0;
        bus.buffer_array  = '0;
        bus.line_prepared = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(pixel_valid), 32'd0);
        check("rst_color", 32'(pixel_color), 32'd0);
        check("rst_done", 32'(render_done), 32'd0);
        check("rst_coll", 32'(sprite_collision), 32'd0);
        check("rst_oam_addr", 32'(bus.oam_addr), 32'd0);
        check("rst_spr_addr", 32'(bus.spr_addr), 32'd0);
        reset_n = 1'b1;

        // Single sprite: row 2 of ref 5 at x=100
        oam_mem[3]       = mk_oam(1, 0, 0, 0, 10'd8, 10'd100, 8'd5);
        spr_mem[12'h052] = {16{4'h7}};
        bus.buffer_array = mk_list(1, 6'd3, 6'd0, 6'd0);
        render_line(10'd10);
        bus.buffer_array = '0;
        render_line(10'd11);
        px("s_99", 10'd99, 1'b0, 4'h0);
        px("s_100", 10'd100, 1'b1, 4'h7);
        check("s_100_prio", 32'(pixel_priority), 32'd0);
        px("s_115", 10'd115, 1'b1, 4'h7);
        px("s_116", 10'd116, 1'b0, 4'h0);

        // X-flip (and y-flip: row 0 fetches row 15)
        oam_mem[4]       = mk_oam(1, 1, 1, 0, 10'd20, 10'd0, 8'd6);
        spr_mem[12'h060] = {16{4'hE}};
        spr_mem[12'h06F] = 64'h2222_2222_2222_2221;
        bus.buffer_array = mk_list(1, 6'd4, 6'd0, 6'd0);
        render_line(10'd20);
        bus.buffer_array = '0;
        render_line(10'd21);
        px("xf_15", 10'd15, 1'b1, 4'h1);
        px("xf_0", 10'd0, 1'b1, 4'h2);
        px("xf_16", 10'd16, 1'b0, 4'h0);

        // Overlap: lower list index wins
        oam_mem[1]       = mk_oam(1, 0, 0, 1, 10'd30, 10'd50, 8'd7);
        oam_mem[2]       = mk_oam(1, 0, 0, 0, 10'd30, 10'd58, 8'd8);
        spr_mem[12'h070] = {16{4'h3}};
        spr_mem[12'h080] = {16{4'h9}};
        bus.buffer_array = mk_list(2, 6'd1, 6'd2, 6'd0);
        render_line(10'd30);
        check("ov_collision", 32'(sprite_collision), 32'(ExpColl));
        bus.buffer_array = '0;
        render_line(10'd31);
        check("ov_coll_cleared", 32'(sprite_collision), 32'd0);
        px("ov_57", 10'd57, 1'b1, 4'h3);
        px("ov_58", 10'd58, 1'b1, 4'h3);
        check("ov_58_prio", 32'(pixel_priority), 32'd1);
        px("ov_65", 10'd65, 1'b1, 4'h3);
        px("ov_66", 10'd66, 1'b1, 4'h9);
        check("ov_66_prio", 32'(pixel_priority), 32'd0);
        px("ov_73", 10'd73, 1'b1, 4'h9);
        px("ov_74", 10'd74, 1'b0, 4'h0);

        // Right edge, disabled sprite, row out of range
        oam_mem[10]      = mk_oam(1, 0, 0, 0, 10'd40, 10'd630, 8'd9);
        oam_mem[11]      = mk_oam(0, 0, 0, 0, 10'd40, 10'd300, 8'd9);
        oam_mem[12]      = mk_oam(1, 0, 0, 0, 10'd20, 10'd400, 8'd9);
        spr_mem[12'h090] = {16{4'h5}};
        spr_mem[12'h094] = {16{4'hA}};
        bus.buffer_array = mk_list(3, 6'd10, 6'd11, 6'd12);
        render_line(10'd40);
        bus.buffer_array = '0;
        render_line(10'd41);
        px("re_630", 10'd630, 1'b1, 4'h5);
        px("re_639", 10'd639, 1'b1, 4'h5);
        px("re_0", 10'd0, 1'b0, 4'h0);
        px("re_5", 10'd5, 1'b0, 4'h0);
        px("re_640", 10'd640, 1'b0, 4'h0);
        px("re_dis_300", 10'd300, 1'b0, 4'h0);
        px("re_row_400", 10'd400, 1'b0, 4'h0);

        // Abort during DRAW of entry 2, after 4 of its pixels are written
        oam_mem[20]      = mk_oam(1, 0, 0, 0, 10'd50, 10'd200, 8'd7);
        oam_mem[21]      = mk_oam(1, 0, 0, 0, 10'd50, 10'd220, 8'd7);
        oam_mem[22]      = mk_oam(1, 0, 0, 0, 10'd50, 10'd240, 8'd7);
        bus.buffer_array = mk_list(3, 6'd20, 6'd21, 6'd22);
        @(negedge clk);
        sy = 10'd50;
        bus.line_prepared = 1'b1;
        wait_draw(2);
        repeat (4) @(negedge clk);
        sy = 10'd51;
        bus.line_prepared = 1'b0;
        @(posedge clk);
        #1;
        check("ab_state", 32'(dut.state_q), 32'(StWaitReady));
        check("ab_done", 32'(render_done), 32'd0);
        px("ab_200", 10'd200, 1'b1, 4'h3);
        px("ab_243", 10'd243, 1'b1, 4'h3);
        px("ab_244", 10'd244, 1'b0, 4'h0);
        bus.buffer_array = '0;
        render_line(10'd52);
        px("ab_new_200", 10'd200, 1'b0, 4'h0);
        px("ab_new_243", 10'd243, 1'b0, 4'h0);

        // Reset mid-DRAW
        bus.buffer_array = mk_list(1, 6'd3, 6'd0, 6'd0);
        @(negedge clk);
        sy = 10'd10;
        bus.line_prepared = 1'b1;
        wait_draw(0);
        reset_n = 1'b0;
        #1;
        check("mr_valid", 32'(pixel_valid), 32'd0);
        check("mr_color", 32'(pixel_color), 32'd0);
        check("mr_prio", 32'(pixel_priority), 32'd0);
        check("mr_done", 32'(render_done), 32'd0);
        check("mr_coll", 32'(sprite_collision), 32'd0);
        check("mr_oam_addr", 32'(bus.oam_addr), 32'd0);
        check("mr_spr_addr", 32'(bus.spr_addr), 32'd0);
        bus.line_prepared = 1'b0;
        bus.buffer_array  = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        px("mr_100", 10'd100, 1'b0, 4'h0);
        px("mr_58", 10'd58, 1'b0, 4'h0);
        px("mr_630", 10'd630, 1'b0, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sprite_line_renderer.md
Name: sprite_line_renderer

Overview:
- Downstream stage of the per-line sprite evaluator.
- Consumes the evaluator's buffer array, a packed list of up to maxObjectPerLine entries, each {OAM index, valid}. Starts when the evaluator raises line_prepared.
- For each listed sprite it re-reads OAM, fetches one 16-pixel row from sprite memory, and draws it into the back half of a double-buffered line memory.
- The front half is read by the pixel output at sx. Halves swap on every sy change.

Parameters:
- maxObjectPerLine, 32, entries in buffer_array
- OAM_ADDR_SIZE, 6, OAM index width
- LINE_WIDTH, 640, pixels per line
- SPRITE_ADDR_SIZE, 12, sprite memory address width ({spriteref[7:0], row[3:0]})

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- sx  in  10  current pixel x
- sy  in  10  current line; any change starts a new line
- buffer_array  in  maxObjectPerLine*(OAM_ADDR_SIZE+1)  entry[OAM_ADDR_SIZE:1]=OAM index, [0]=valid
- line_prepared  in  1  buffer_array is stable and complete for the current sy
- oam_addr  out  OAM_ADDR_SIZE  OAM read address (second read port), 1-cycle latency
- oam_data  in  32  [31] enable, [30] y-flip, [29] x-flip, [28] priority, [27:18] ypos, [17:8] xpos, [7:0] spriteref
- spr_addr  out  SPRITE_ADDR_SIZE  sprite row address, 1-cycle latency
- spr_data  in  64  16 pixels × 4 bpp; pixel i = [4i+3:4i]; 0 = transparent
- pixel_color  out  4  front-buffer color at sx
- pixel_priority  out  1  priority bit of that pixel
- pixel_valid  out  1  a sprite pixel is present at sx
- render_done  out  1  back buffer complete for this line
- sprite_collision  out  1  sticky overlap flag (see Optional Feature)

Behaviour:
- Reset (reset_n=0, async): FSM=IDLE, all outputs 0, valid masks of both halves cleared, front select=0.
- Line memory: 2 × LINE_WIDTH × {color[3:0], priority}. Each half has a LINE_WIDTH-bit valid mask held in flops, so it clears in one cycle.
- Swap, on the cycle sy changes:
  - front/back exchange.
  - New back mask cleared.
  - FSM forced to WAIT_READY, including mid-render abort.
  - render_done←0.
- Output: pixel_* reflect front[sx] one cycle after sx. sx≥LINE_WIDTH gives pixel_valid=0.
- FSM:
  - IDLE → WAIT_READY after reset.
  - WAIT_READY: idx←0. When line_prepared=1 and no sy change this cycle → OAM_FETCH.
  - OAM_FETCH: oam_addr←entry[idx] index. If entry[idx].valid=0 or idx=maxObjectPerLine → DONE, since the list is packed.
  - OAM_LATCH: latch oam_data.
    - row = sy − ypos (10-bit), 4 LSBs, inverted if y-flip.
    - If enable=0 or row out of range (0..15) → skip to NEXT.
    - Else spr_addr←{spriteref,row} → SPR_FETCH.
  - SPR_FETCH: latch spr_data → DRAW with i←0.
  - DRAW: one pixel per cycle, i=0..15.
    - Source pixel is index i, or 15−i if x-flip. Target x = xpos + i, 11-bit.
    - Write only if x<LINE_WIDTH, pixel≠0, and back mask[x]=0. Lower list index wins; no wrap.
    - At i=15 → NEXT.
  - NEXT: idx+1 → OAM_FETCH.
  - DONE: render_done=1. Hold until sy changes.
- Worst case: 32 × (2 + 1 + 16 + 1) = 640 cycles. This fits an 800-clock line.
- line_prepared dropping mid-render: ignored. Only an sy change aborts.

Optional Feature:
- SPRITE_COLLISION_EN defined:
  - sprite_collision←1 when a DRAW pixel ≠0 hits x with back mask[x]=1.
  - Sticky until the next swap, then 0.
- Undefined: sprite_collision tied 0 and no detection logic is generated.

Decomposition:
- Shared package sprite_pkg:
  - oam_entry_t packed struct (fields above), TRANSPARENT=4'h0, SPRITE_H=16, SPRITE_W=16.
  - renderer state enum.
- Sub-module line_buffer_dp: one half of the line memory plus its valid mask. It has a write port, a read port, and a 1-cycle clear. It is instantiated twice.

Test Plan:
- Single sprite: entry0={idx 3,1}; OAM[3] xpos=100, ypos=sy−2, spriteref=5; spr_data all 4'h7 → after next sy change, pixel_color=7 at sx 100..115, pixel_valid=0 at 99 and 116.
- X-flip: spr_data pixel0=1, others 2, x-flip=1, xpos=0 → next line sx=15 reads 1, sx=0 reads 2.
- Overlap and priority:
  - Entry0 sprite color 3 at x=50, entry1 color 9 at x=58 → x 58..65 show 3, x 66..73 show 9.
  - With SPRITE_COLLISION_EN, sprite_collision=1.
- Right edge: xpos=630 → pixels 630..639 written, no wrap to 0..5; render_done=1.
- Abort: change sy during DRAW of entry 2 → FSM in WAIT_READY next cycle, render_done=0, new back mask all 0.
- Reset mid-DRAW: reset_n=0 → all outputs 0 immediately, pixel_valid=0 everywhere after release.
